// File: rtl/exe_muldiv_unit.sv
// Iterative RV32M multiply/divide: one shared 32-step shift-add / restoring shift-subtract datapath.
// Latency 33 cycles (1 for divide-by-zero / overflow); holds the pipeline via stall_req, flush aborts.
module exe_muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            flush,
   output logic            busy,
   output logic            stall_req,
   output logic            done,
   output logic [XLEN-1:0] result
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t                r_state, w_state_nxt;
   logic [CNT_W-1:0]      r_cnt;
   logic [2:0]            r_funct3;
   logic [2*XLEN-1:0]     r_acc;
   logic [XLEN-1:0]       r_b;
   logic                  r_neg_q, r_neg_r;
   logic                  r_busy, r_done;
   logic [XLEN-1:0]       r_result;

   logic                  w_launch, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
   logic                  w_div0, w_ovf, w_special, w_ge;
   logic [XLEN-1:0]       w_a_mag, w_b_mag, w_spec_res, w_sub, w_quo, w_rem, w_fin;
   logic [XLEN:0]         w_mul_sum, w_rem_sh;
   logic [2*XLEN-1:0]     w_mul_nxt, w_div_nxt, w_acc_nxt, w_prod;

   // Operand signedness: MUL/MULH/MULHSU/DIV/REM treat op_a as signed; only MUL/MULH/DIV/REM sign op_b.
   always_comb begin
      w_launch   = (r_state == S_IDLE) & start & ~flush;
      w_a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
      w_b_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
      w_a_neg    = w_a_signed & op_a[XLEN-1];
      w_b_neg    = w_b_signed & op_b[XLEN-1];
      w_a_mag    = w_a_neg ? -op_a : op_a;
      w_b_mag    = w_b_neg ? -op_b : op_b;
      w_div0     = funct3[2] & (op_b == '0);
      w_ovf      = funct3[2] & ~funct3[0] & (op_a == 32'h8000_0000) & (op_b == '1);
      w_special  = w_div0 | w_ovf;
      if (w_div0) w_spec_res = funct3[1] ? op_a : '1;
      else        w_spec_res = funct3[1] ? '0 : 32'h8000_0000;
   end

   // One iteration: acc = {hi, lo}; lo holds multiplier / dividend bits being consumed.
   always_comb begin
      w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
      w_mul_nxt = {w_mul_sum, r_acc[XLEN-1:1]};
      w_rem_sh  = r_acc[2*XLEN-1:XLEN-1];
      w_ge      = (w_rem_sh >= {1'b0, r_b});
      w_sub     = w_rem_sh[XLEN-1:0] - r_b;
      w_div_nxt = w_ge ? {w_sub, r_acc[XLEN-2:0], 1'b1} : {r_acc[2*XLEN-2:0], 1'b0};
      w_acc_nxt = r_funct3[2] ? w_div_nxt : w_mul_nxt;
      w_prod    = r_neg_q ? -w_acc_nxt : w_acc_nxt;
      w_quo     = r_neg_q ? -w_acc_nxt[XLEN-1:0] : w_acc_nxt[XLEN-1:0];
      w_rem     = r_neg_r ? -w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[2*XLEN-1:XLEN];
      case (r_funct3)
         3'b000:         w_fin = w_prod[XLEN-1:0];
         3'b100, 3'b101: w_fin = w_quo;
         3'b110, 3'b111: w_fin = w_rem;
         default:        w_fin = w_prod[2*XLEN-1:XLEN];
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_launch) w_state_nxt = w_special ? S_DONE : S_BUSY;
         S_BUSY:  if (flush) w_state_nxt = S_IDLE;
                  else if (r_cnt == '1) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      stall_req = ~rst & (w_launch | (r_state == S_BUSY));
      busy      = r_busy;
      done      = r_done;
      result    = r_result;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_funct3 <= '0;
         r_acc    <= '0;
         r_b      <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
      end else begin
         r_busy <= (w_state_nxt == S_BUSY);
         r_done <= (w_state_nxt == S_DONE);
         if (w_launch) begin
            r_funct3 <= funct3;
            r_acc    <= {{XLEN{1'b0}}, w_a_mag};
            r_b      <= w_b_mag;
            r_cnt    <= '0;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            if (w_special) r_result <= w_spec_res;
         end else if (r_state == S_BUSY && !flush) begin
            r_acc <= w_acc_nxt;
            if (r_cnt == '1) r_result <= w_fin;
            else             r_cnt    <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Directed bench for exe_muldiv_unit: hand-computed results, latency, stall and flush/reset behaviour.
`timescale 1ns/1ps
module tb_exe_muldiv_unit;

   logic        clk, rst, start, flush;
   logic [2:0]  funct3;
   logic [31:0] op_a, op_b;
   logic        busy, stall_req, done;
   logic [31:0] result;

   int n_tests = 0;
   int n_fail  = 0;

   exe_muldiv_unit dut (
      .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
      .flush(flush), .busy(busy), .stall_req(stall_req), .done(done), .result(result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Launch one op like a stalled pipeline would (start held until done), measure what comes back.
   task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output logic saw_busy,
                        output logic stall_ok, output logic pulse_ok);
      @(negedge clk);
      funct3 = f; op_a = a; op_b = b; start = 1'b1;
      #1;
      stall_ok = (stall_req === 1'b1);
      saw_busy = 1'b0;
      lat = 0;
      while (done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
         if (busy === 1'b1) saw_busy = 1'b1;
         if (done !== 1'b1 && stall_req !== 1'b1) stall_ok = 1'b0;
      end
      res = result;
      if (stall_req !== 1'b0) stall_ok = 1'b0;
      @(negedge clk);
      start = 1'b0;
      pulse_ok = (done === 1'b0) && (busy === 1'b0);
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b1; flush = 1'b0; funct3 = 3'b000; op_a = 32'd1; op_b = 32'd1;
      repeat (3) @(negedge clk);
      n_tests++;
      if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall_req); end
      start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({busy, done, stall_req} !== 3'b000 || result !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_state: got busy=%b done=%b stall=%b result=%h expected 0/0/0/00000000",
                  busy, done, stall_req, result);
      end
   endtask

   task automatic test_ops(input string name, input logic [2:0] f[4], input logic [31:0] a[4],
                           input logic [31:0] b[4], input logic [31:0] exp[4], input int exp_lat);
      int lat; logic [31:0] res; logic sb, so, po;
      for (int i = 0; i < 4; i++) begin
         do_op(f[i], a[i], b[i], lat, res, sb, so, po);
         n_tests++;
         if (res !== exp[i]) begin n_fail++; $display("FAIL %s[%0d]_result: got %h expected %h", name, i, res, exp[i]); end
         n_tests++;
         if (lat !== exp_lat) begin n_fail++; $display("FAIL %s[%0d]_latency: got %0d expected %0d", name, i, lat, exp_lat); end
         n_tests++;
         if (so !== 1'b1 || po !== 1'b1 || sb !== (exp_lat > 1)) begin
            n_fail++;
            $display("FAIL %s[%0d]_handshake: got stall_ok=%b pulse_ok=%b saw_busy=%b expected 1/1/%b",
                     name, i, so, po, sb, exp_lat > 1);
         end
      end
   endtask

   task automatic test_mul;
      test_ops("mul", '{3'b000, 3'b001, 3'b011, 3'b010},
               '{32'd7, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF},
               '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF},
               '{32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF}, 33);
      test_ops("mul2", '{3'b000, 3'b000, 3'b001, 3'b011},
               '{32'h00010000, 32'd3, 32'h80000000, 32'h80000000},
               '{32'h00010000, 32'd4, 32'h80000000, 32'h80000000},
               '{32'h00000000, 32'd12, 32'h40000000, 32'h40000000}, 33);
   endtask

   task automatic test_div;
      test_ops("div", '{3'b100, 3'b110, 3'b101, 3'b111},
               '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100},
               '{32'd2, 32'd2, 32'd7, 32'd7},
               '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2}, 33);
   endtask

   // Divide-by-zero and signed overflow finish without iterating: done on the first cycle after launch.
   task automatic test_div_special;
      test_ops("divspec", '{3'b100, 3'b110, 3'b100, 3'b110},
               '{32'd5, 32'd5, 32'h80000000, 32'h80000000},
               '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF},
               '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0}, 1);
   endtask

   task automatic test_flush;
      logic saw_done;
      test_ops("flushpre", '{3'b101, 3'b111, 3'b101, 3'b101},
               '{32'd7, 32'd9, 32'd1, 32'd7},
               '{32'd0, 32'd0, 32'd0, 32'd0},
               '{32'hFFFFFFFF, 32'd9, 32'hFFFFFFFF, 32'hFFFFFFFF}, 1);
      @(negedge clk);
      funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
      repeat (10) @(negedge clk);
      n_tests++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_before: got %b expected 1", busy); end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; start = 1'b0;
      n_tests++;
      if ({busy, done} !== 2'b00 || result !== 32'hFFFFFFFF) begin
         n_fail++;
         $display("FAIL flush_abort: got busy=%b done=%b result=%h expected 0/0/ffffffff", busy, done, result);
      end
      saw_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
      end
      n_tests++;
      if (saw_done !== 1'b0) begin n_fail++; $display("FAIL flush_no_done: got activity=%b expected 0", saw_done); end
      funct3 = 3'b000; op_a = 32'd3; op_b = 32'd4; start = 1'b1; flush = 1'b1;
      #1;
      n_tests++;
      if (stall_req !== 1'b0) begin n_fail++; $display("FAIL flush_idle_stall: got %b expected 0", stall_req); end
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      n_tests++;
      if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL flush_idle_launch: got busy=%b done=%b expected 0/0", busy, done); end
      test_ops("flushpost", '{3'b000, 3'b000, 3'b000, 3'b000},
               '{32'd3, 32'd3, 32'd3, 32'd3},
               '{32'd4, 32'd4, 32'd4, 32'd4},
               '{32'd12, 32'd12, 32'd12, 32'd12}, 33);
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      funct3 = 3'b000; op_a = 32'd5; op_b = 32'd5; start = 1'b1;
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if ({busy, done, stall_req} !== 3'b000 || result !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_mid: got busy=%b done=%b stall=%b result=%h expected 0/0/0/00000000",
                  busy, done, stall_req, result);
      end
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      test_ops("postrst", '{3'b011, 3'b011, 3'b001, 3'b000},
               '{32'd2, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE},
               '{32'd3, 32'd3, 32'd3, 32'd3},
               '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFA}, 33);
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_div_special();
      test_flush();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
